// File: rtl/instr_seq_pkg.sv
// Shared types for the instruction sequencer: opcode and FSM state encodings,
// the HALT opcode constant and the issuable-opcode decode.
package instr_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NOT  = 4'h6,
    OP_HALT = 4'hE,
    OP_LDI  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DONE
  } state_e;

  localparam logic [3:0] HALT_OP = 4'hE;

  // Opcodes that are handed to the ALU; HALT and 0111..1101 never are.
  function automatic logic op_issuable(input logic [3:0] op);
    return (op <= 4'h6) || (op == 4'hF);
  endfunction

endpackage

// File: rtl/instr_sequencer_mem.sv
// Program memory: one synchronous write port, one registered read port.
// rst clears only the read register, never the stored program.
module instr_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches program words and issues them to an ALU with
// a valid/ready handshake. Define ILLEGAL_OP_TRAP_EN to trap illegal opcodes.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  input  logic          start,
  output logic [15:0]   instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] pc,
  output logic [AW:0]   issue_cnt
);

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [AW:0]   cnt_q;
  logic          error_q;
  logic [15:0]   rdata;
  logic [3:0]    opcode;
  logic          at_rest;
  logic          last_pc;
  logic          mem_we;

  assign at_rest = (state_q == S_IDLE) || (state_q == S_DONE);
  assign mem_we  = load_valid && at_rest && !rst;
  assign opcode  = rdata[15:12];
  assign last_pc = (pc_q == AW'(DEPTH - 1));

  instr_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (16)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (mem_we),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .re_i    (state_q == S_FETCH),
    .raddr_i (pc_q),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc_q    <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_ISSUE;
        S_ISSUE: begin
          if (op_issuable(opcode)) begin
            if (instr_ready) begin
              cnt_q <= cnt_q + 1'b1;
              if (last_pc) state_q <= S_DONE;
              else begin
                pc_q    <= pc_q + 1'b1;
                state_q <= S_FETCH;
              end
            end
          end else if (opcode == HALT_OP) begin
            state_q <= S_DONE;
          end else begin
`ifdef ILLEGAL_OP_TRAP_EN
            error_q <= 1'b1;
            state_q <= S_DONE;
`else
            // Illegal word is skipped: advance exactly like a handshake, no count.
            if (last_pc) state_q <= S_DONE;
            else begin
              pc_q    <= pc_q + 1'b1;
              state_q <= S_FETCH;
            end
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr       = rdata;
  assign instr_valid = (state_q == S_ISSUE) && op_issuable(opcode);
  assign busy        = !at_rest;
  assign done        = (state_q == S_DONE);
  assign error       = error_q;
  assign pc          = pc_q;
  assign issue_cnt   = cnt_q;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst; no other clock or reset SHALL exist.
REQ-002 DEPTH, default 16, SHALL set the number of program-memory entries.
REQ-003 AW, default 4, SHALL equal $clog2(DEPTH) and set the address width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 load_valid  input  1  program-memory write strobe.
REQ-007 load_addr  input  AW  write address.
REQ-008 load_data  input  16  instruction word to store.
REQ-009 start  input  1  one-cycle pulse that begins execution at address 0.
REQ-010 instr  output  16  instruction word presented to the ALU.
REQ-011 instr_valid  output  1  instr holds a word to be issued.
REQ-012 instr_ready  input  1  ALU accepts instr this cycle.
REQ-013 busy  output  1  sequencer is not in IDLE or DONE.
REQ-014 done  output  1  high while in DONE.
REQ-015 error  output  1  sticky illegal-opcode flag.
REQ-016 pc  output  AW  current program counter.
REQ-017 issue_cnt  output  AW+1  instructions accepted since the last start.

Function
REQ-018 The states SHALL be IDLE, FETCH, ISSUE and DONE.
REQ-019 IDLE or DONE with start=1 SHALL clear pc, issue_cnt and error and enter FETCH on the next edge.
REQ-020 FETCH SHALL perform a registered read of mem[pc] and enter ISSUE; instr SHALL be valid one cycle after FETCH.
REQ-021 In ISSUE with opcode instr[15:12] in {0000..0110, 1111}, instr_valid SHALL be 1 and instr SHALL stay stable until instr_valid and instr_ready are both high.
REQ-022 On handshake: issue_cnt++; if pc==DEPTH-1, enter DONE with pc unchanged; otherwise pc++ and enter FETCH.
REQ-023 Issue throughput SHALL be one instruction per 2 cycles maximum.
REQ-024 Opcode 1110 (HALT) SHALL not be issued: instr_valid stays 0, and the block enters DONE with pc held at the HALT address.
REQ-025 Opcodes 0111..1101 are illegal; handling is set by REQ-033/034.
REQ-026 instr_ready while instr_valid=0 SHALL be ignored.
REQ-027 load_valid SHALL write mem[load_addr] only in IDLE or DONE; writes while busy=1 SHALL be dropped.
REQ-028 load_valid and start in the same cycle: the write SHALL complete, and the fetch SHALL see the new data.
REQ-029 start while busy=1 SHALL be ignored.

Reset
REQ-030 rst SHALL force IDLE, pc=0, issue_cnt=0, instr=0, instr_valid=0, busy=0, done=0 and error=0 at the next edge, including during ISSUE.
REQ-031 Program-memory contents SHALL NOT be cleared by rst.
REQ-032 rst SHALL take priority over start and load_valid.

Configuration
REQ-033 With ILLEGAL_OP_TRAP_EN defined, an illegal opcode in ISSUE SHALL set error, suppress instr_valid and enter DONE.
REQ-034 Without ILLEGAL_OP_TRAP_EN, an illegal opcode SHALL be skipped silently with error held at 0; pc advances as in REQ-022 and issue_cnt does not increment.

Structure
REQ-035 Package instr_seq_pkg SHALL hold the opcode enum (ADD, SUB, MUL, AND, OR, XOR, NOT, HALT=1110, LDI=1111), the state enum, and the HALT_OP constant.
REQ-036 Program memory SHALL be a sub-module named instr_mem, with one synchronous write port and one synchronous read port.

Verification
REQ-037 Load mem[0..2]={0x0123, 0x1456, 0xE000}, start, ready=1 -> 0x0123 then 0x1456 issued, done=1, pc=2, issue_cnt=2.
REQ-038 Same program with ready low for 5 cycles on the first word -> instr=0x0123 stable across all 5 cycles, then issued once.
REQ-039 mem[0]=0x7000 -> with the macro: error=1, done=1, no issue; without the macro: word skipped, mem[1] issued.
REQ-040 All 16 entries hold 0xF0AA (LDI) -> 16 issues, done=1, pc=15, issue_cnt=16, no wrap to 0.
REQ-041 rst asserted mid-ISSUE, then start -> instr_valid=0 the cycle after rst; the program reruns from mem[0] unchanged.
REQ-042 load_valid while busy=1 -> memory unchanged; a later run issues the original word.
